fp32_add_arbiter: RTL and testbench
===================================

# fp32_add_arbiter

Round-robin arbiter that shares one single-cycle fp32 adder datapath among NUM_REQ independent requesters. Each requester presents an operand pair through a valid/ready handshake. The block registers the granted pair, runs it through the combinational fp32 adder, and registers the result. It returns each result with the originating requester id on a single valid/ready result port. It sits between the per-lane compute front-ends and the shared adder, so the datapath is never duplicated.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- ID_W, $clog2(NUM_REQ): width of the requester id.

Ports:
- clk  in  1  single clock for all state.
- rstn  in  1  reset, asynchronous, active-high. Despite the name, 1 = reset asserted; it clears all state immediately.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- req_sub  in  NUM_REQ  1 = compute A-B by inverting B[31] before the adder.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  32  IEEE-754 single-precision sum, with the adder's rounding, inf and NaN behaviour.
- res_id  out  ID_W  index of the requester that issued this result.
- busy  out  1  s1_valid | res_valid.
- done_cnt  out  16  count of completed result handshakes; wraps modulo 2^16.

## Operation
Pipeline:
- S1 issue register: s1_valid, s1_a, s1_b (sign already adjusted), s1_id.
- S2 result register: res_valid, res_data, res_id.
- The adder is combinational between S1 and S2.

Control equations:
- s2_free = !res_valid | res_ready.
- s1_free = !s1_valid | s2_free.
- S1 advances into S2 when s1_valid & s2_free.
- S2 clears when res_valid & res_ready and nothing advances into it.

Arbitration:
- Round-robin pointer `last` (ID_W bits) holds the last granted id.
- Search order is last+1, last+2, ... wrapping modulo NUM_REQ. The first asserted req_valid wins.
- req_ready[g] = s1_free & req_valid[g] for the winner g; all other bits are 0. req_ready is combinational from req_valid, S1/S2 state and res_ready.
- On a handshake req_valid[g] & req_ready[g]:
  - S1 loads {A_g, B_g ^ (req_sub[g]<<31), g}.
  - `last` <= g.
- `last` does not change when nothing is accepted.
- Requesters must hold operands stable while valid and unaccepted. Deasserting valid before acceptance is allowed; the arbiter re-evaluates every cycle.

Other rules:
- done_cnt increments on each res_valid & res_ready cycle.
- The arbiter applies no special-casing to operands. NaN, inf and zero handling are whatever the adder produces.

Reset (rstn=1, asynchronous):
- s1_valid=0, res_valid=0, res_data=0, res_id=0.
- last=NUM_REQ-1, so requester 0 has top priority first.
- done_cnt=0, busy=0.
- req_ready=0 while reset is asserted.
- In-flight operations are dropped with no result issued.

## Timing
- Latency: a request accepted in cycle T gives res_valid=1 in cycle T+2 when res_ready stays high.
- Throughput: one accept per cycle while res_ready=1.
- Backpressure:
  - res_valid=1 & res_ready=0: S2 holds, with res_data and res_id stable.
  - If S1 is also full, S1 holds and req_ready is all zero.
  - At most 2 operations are in flight.
- Same cycle as a result handshake: S1 may advance into S2 and a new request may load S1. A full pipe with res_ready=1 therefore keeps streaming.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,... and no requester waits more than NUM_REQ-1 accepts.
- Single requester valid: that requester is granted every cycle S1 is free, regardless of `last`.

## Test plan
- **Single op, add:** after reset, req 2 with A=0x3F800000, B=0x40000000, sub=0, res_ready=1 held.
  - req_ready[2]=1 in cycle T.
  - Cycle T+2: res_valid=1, res_data=0x40400000, res_id=2, done_cnt becomes 1 after that cycle.
- **Subtract:** req 1 with A=0x40400000, B=0x3F800000, sub=1 -> res_data=0x40000000, res_id=1.
- **Round-robin:** all 4 valid from reset with distinct operands and res_ready=1.
  - Accept order 0,1,2,3,0.
  - res_id sequence 0,1,2,3 in consecutive cycles starting 2 cycles after the first accept.
- **Backpressure:** res_ready=0 for 5 cycles with 3 requesters valid.
  - Exactly 2 accepts occur, then req_ready stays 0.
  - res_data and res_id are stable for all 5 cycles.
  - On res_ready=1, results drain in order and accepts resume in the same cycle.
- **Reset mid-operation:** assert rstn with S1 and S2 both full.
  - Immediately: res_valid=0, busy=0, done_cnt=0.
  - After deassertion: no stale result; first grant goes to req 0.
- **Counter wrap:** drive 65537 completions -> done_cnt reads 0xFFFF, then 0x0000, then 0x0001.

Source files
------------

// File: rtl/fp32_add_arbiter.sv
// fp32_add_arbiter: round-robin sharing of one fp32 adder among
// NUM_REQ requesters through an issue/result register pipeline.
module fp32_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  function automatic logic [31:0] fp_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [31:0] x, y;
    logic        sx, sub;
    logic [9:0]  ex, ey, e;
    logic [26:0] mx, my, sh, n;
    logic [27:0] s;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic        sticky, rnd;
    logic [24:0] r;
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31])))
      return 32'h7FC0_0000;
    if (a_inf)
      return a;
    if (b_inf)
      return b;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sx  = x[31];
    sub = x[31] ^ y[31];
    // Subnormals share the exponent of the smallest normal.
    ex  = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey  = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx  = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my  = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d   = 8'(ex - ey);
    if (d >= 8'd27) begin
      sh     = 27'd0;
      sticky = |my;
    end else begin
      sh     = my >> d;
      sticky = |(my & ~(27'h7FF_FFFF << d));
    end
    sh[0] = sh[0] | sticky;
    s = sub ? ({1'b0, mx} - {1'b0, sh})
            : ({1'b0, mx} + {1'b0, sh});
    if (s == 28'd0)
      return {sx & ~sub, 31'd0};
    e = ex;
    if (s[27]) begin
      n    = s[27:1];
      n[0] = n[0] | s[0];
      e    = e + 10'd1;
    end else begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++)
        if (s[i])
          lz = 5'(26 - i);
      if ({5'd0, lz} >= e)
        lz = 5'(e - 10'd1);
      n = s[26:0] << lz;
      e = e - {5'd0, lz};
    end
    rnd = n[2] & (n[1] | n[0] | n[3]);
    r   = {1'b0, n[26:3]} + {24'd0, rnd};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255)
      return {sx, 8'hFF, 23'd0};
    return {sx, (r[23] ? e[7:0] : 8'd0), r[22:0]};
  endfunction

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [15:0]     done_q, done_d;

  logic            s2_free, s1_free;
  logic            gnt_vld, accept;
  logic [ID_W-1:0] gnt_id, idx;
  logic [31:0]     sel_a, sel_b, sum;
  logic            sel_sub;

  assign s2_free = !res_valid_q | res_ready;
  assign s1_free = !s1_valid_q | s2_free;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign req_ready = (s1_free && gnt_vld && !rstn)
                   ? (NUM_REQ'(1) << gnt_id) : '0;
  assign accept    = |req_ready;
  assign sel_a     = req_a[32*int'(gnt_id) +: 32];
  assign sel_b     = req_b[32*int'(gnt_id) +: 32];
  assign sel_sub   = req_sub[gnt_id];
  assign sum       = fp_add(s1_a_q, s1_b_q);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    last_d      = last_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (s1_free) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = sel_a;
        s1_b_d  = sel_b ^ {sel_sub, 31'd0};
        s1_id_d = gnt_id;
        last_d  = gnt_id;
      end
    end
    if (s2_free) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_data_d = sum;
        res_id_d   = s1_id_q;
      end
    end
    done_d = done_q + {15'd0, res_valid_q & res_ready};
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      done_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q | res_valid_q;
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter: arithmetic, latency,
// round-robin order, backpressure, async reset and counter wrap.
module tb_fp32_add_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]  req_sub;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [1:0]    res_id;
  logic          busy;
  logic [15:0]   done_cnt;

  int n_chk;
  int n_fail;

  logic [31:0] rr_exp [4] = '{32'h4000_0000, 32'h4040_0000,
                              32'h4080_0000, 32'h4100_0000};

  fp32_add_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i]        = s;
  endtask

  task automatic set_rr_ops();
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    set_op(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    set_op(2, 32'h4000_0000, 32'h4000_0000, 1'b0);
    set_op(3, 32'h4080_0000, 32'h4080_0000, 1'b0);
  endtask

  task automatic pulse_reset();
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    set_rr_ops();
    res_ready = 1'b1;
    rstn      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b exp 0000", req_ready);
    end
    n_chk++;
    if ({res_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_valid_busy: got %b exp 00", {res_valid, busy});
    end
    n_chk++;
    if ({res_data, res_id, done_cnt} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_regs: data %h id %0d cnt %0d exp 0",
               res_data, res_id, done_cnt);
    end
    req_valid = 4'h0;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  task automatic test_single_add();
    set_op(2, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b exp 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: res_valid got %b exp 0", res_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({res_valid, res_data, res_id} !== {1'b1, 32'h4040_0000, 2'd2}) begin
      n_fail++;
      $display("FAIL single_result: v %b data %h id %0d exp 1 40400000 2",
               res_valid, res_data, res_id);
    end
    n_chk++;
    if (done_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL single_cnt_before: got %0d exp 0", done_cnt);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done_cnt !== 16'd1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cnt_after: cnt %0d v %b exp 1 0",
               done_cnt, res_valid);
    end
  endtask

  task automatic test_arith();
    int          v_id  [10] = '{1, 0, 3, 2, 1, 0, 3, 0, 1, 2};
    logic [31:0] v_a   [10] = '{32'h4040_0000, 32'h3F00_0000,
                                32'h3F80_0000, 32'h7F80_0000,
                                32'h7F80_0000, 32'h7F7F_FFFF,
                                32'h40A0_0000, 32'h3F80_0000,
                                32'h3F80_0000, 32'h0000_0001};
    logic [31:0] v_b   [10] = '{32'h3F80_0000, 32'h3E80_0000,
                                32'h3F80_0000, 32'h3F80_0000,
                                32'h7F80_0000, 32'h7F7F_FFFF,
                                32'hC040_0000, 32'h3380_0000,
                                32'h33C0_0000, 32'h0000_0001};
    logic        v_s   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] v_exp [10] = '{32'h4000_0000, 32'h3F40_0000,
                                32'h0000_0000, 32'h7F80_0000,
                                32'h7FC0_0000, 32'h7F80_0000,
                                32'h4000_0000, 32'h3F80_0000,
                                32'h3F80_0001, 32'h0000_0002};
    for (int v = 0; v < 10; v++) begin
      set_op(v_id[v], v_a[v], v_b[v], v_s[v]);
      req_valid = 4'b0001 << v_id[v];
      @(negedge clk);
      n_chk++;
      if (req_ready !== (4'b0001 << v_id[v])) begin
        n_fail++;
        $display("FAIL arith_ready[%0d]: got %b exp id %0d",
                 v, req_ready, v_id[v]);
      end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (res_valid !== 1'b1 || res_data !== v_exp[v]) begin
        n_fail++;
        $display("FAIL arith_data[%0d]: v %b data %h exp %h",
                 v, res_valid, res_data, v_exp[v]);
      end
      n_chk++;
      if (res_id !== 2'(v_id[v])) begin
        n_fail++;
        $display("FAIL arith_id[%0d]: got %0d exp %0d", v, res_id, v_id[v]);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (done_cnt !== 16'd11) begin
      n_fail++;
      $display("FAIL arith_cnt: got %0d exp 11", done_cnt);
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    set_rr_ops();
    res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 7) ? 4'hF : 4'h0;
      @(negedge clk);
      n_chk++;
      if (req_ready !== ((k < 7) ? (4'b0001 << (k % 4)) : 4'b0000)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b", k, req_ready);
      end
      if (k < 2) begin
        n_chk++;
        if (res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_early[%0d]: res_valid got %b exp 0", k, res_valid);
        end
      end else begin
        n_chk++;
        if (res_valid !== 1'b1 || res_id !== 2'((k - 2) % 4) ||
            res_data !== rr_exp[(k - 2) % 4]) begin
          n_fail++;
          $display("FAIL rr_result[%0d]: v %b id %0d data %h exp id %0d",
                   k, res_valid, res_id, res_data, (k - 2) % 4);
        end
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (done_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL rr_cnt: got %0d exp 7", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy [9] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000,
                                4'b0000, 4'b0010, 4'b1000, 4'b0000,
                                4'b0000};
    logic       exp_rv  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1};
    int         exp_id  [9] = '{0, 0, 3, 3, 3, 3, 0, 1, 3};
    for (int c = 0; c < 9; c++) begin
      res_ready = (c >= 5);
      req_valid = (c < 7) ? 4'b1011 : 4'b0000;
      @(negedge clk);
      n_chk++;
      if (req_ready !== exp_rdy[c]) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b exp %b", c, req_ready, exp_rdy[c]);
      end
      n_chk++;
      if (res_valid !== exp_rv[c]) begin
        n_fail++;
        $display("FAIL bp_valid[%0d]: got %b exp %b", c, res_valid, exp_rv[c]);
      end
      if (exp_rv[c]) begin
        n_chk++;
        if (res_id !== 2'(exp_id[c]) || res_data !== rr_exp[exp_id[c]]) begin
          n_fail++;
          $display("FAIL bp_result[%0d]: id %0d data %h exp id %0d data %h",
                   c, res_id, res_data, exp_id[c], rr_exp[exp_id[c]]);
        end
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (done_cnt !== 16'd11 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_cnt: cnt %0d v %b exp 11 0", done_cnt, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    req_valid = 4'b0110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy, res_valid, req_ready} !== {1'b1, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_full: busy %b v %b ready %b exp 1 1 0000",
               busy, res_valid, req_ready);
    end
    #2;
    rstn = 1'b1;
    #1;
    n_chk++;
    if ({res_valid, busy} !== 2'b00 || done_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_clear: v %b busy %b cnt %0d exp 0 0 0",
               res_valid, busy, done_cnt);
    end
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_ready: got %b exp 0000", req_ready);
    end
    @(posedge clk); #1;
    rstn      = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_grant: ready %b v %b exp 0001 0", req_ready, res_valid);
    end
    @(posedge clk); #1;
    req_valid = 4'h0;
    @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stale: res_valid got %b exp 0", res_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 ||
        res_data !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL mid_result: v %b id %0d data %h exp 1 0 40000000",
               res_valid, res_id, res_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    pulse_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (65537) @(posedge clk);
    #1;
    n_chk++;
    if (done_cnt !== 16'hFFFF || res_valid !== 1'b1 || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_ffff: cnt %h v %b id %0d exp ffff 1 0",
               done_cnt, res_valid, res_id);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_0000: got %h exp 0000", done_cnt);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done_cnt !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_0001: got %h exp 0001", done_cnt);
    end
    req_valid = 4'h0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rstn      = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    res_ready = 1'b1;
    test_reset();
    test_single_add();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
